// File: rtl/mask_feature_extractor_pkg.sv
// rtl/mask_feature_extractor_pkg.sv - shared frame geometry, state encoding and feature record type
package mask_feature_extractor_pkg;

  localparam int LENGTH = 64;
  localparam int WIDTH  = 64;
  localparam int CNT_W  = $clog2(LENGTH * WIDTH + 1);
  localparam int ROW_W  = $clog2(LENGTH);
  localparam int COL_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [ROW_W-1:0] min_row;
    logic [ROW_W-1:0] max_row;
    logic [COL_W-1:0] min_col;
    logic [COL_W-1:0] max_col;
    logic             empty;
  } feat_t;

endpackage

// File: rtl/row_span_popcount.sv
// rtl/row_span_popcount.sv - popcount and lowest/highest set-bit index of one mask row
module row_span_popcount #(
  parameter int WIDTH = 64,
  parameter int PC_W  = $clog2(WIDTH + 1),
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] row,
  output logic [PC_W-1:0]  popcount,
  output logic [IDX_W-1:0] first,
  output logic [IDX_W-1:0] last,
  output logic             any
);

  always_comb begin
    popcount = '0;
    first    = '0;
    last     = '0;
    // Descending scan leaves the lowest set index in first; ascending leaves the highest in last.
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (row[j]) first = IDX_W'(j);
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (row[j]) last = IDX_W'(j);
      popcount = popcount + PC_W'(row[j]);
    end
    any = |row;
  end

endmodule

// File: rtl/mask_feature_extractor.sv
// rtl/mask_feature_extractor.sv - accumulates per-frame pixel count and bounding box of a binary mask
module mask_feature_extractor #(
  parameter int LENGTH = mask_feature_extractor_pkg::LENGTH,
  parameter int WIDTH  = mask_feature_extractor_pkg::WIDTH,
  parameter int CNT_W  = $clog2(LENGTH * WIDTH + 1),
  parameter int ROW_W  = $clog2(LENGTH),
  parameter int COL_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic             row_sof,
  input  logic [WIDTH-1:0] row_data,
  output logic             feat_valid,
  input  logic             feat_ready,
  output logic [CNT_W-1:0] feat_count,
  output logic [ROW_W-1:0] feat_min_row,
  output logic [ROW_W-1:0] feat_max_row,
  output logic [COL_W-1:0] feat_min_col,
  output logic [COL_W-1:0] feat_max_col,
  output logic             feat_empty,
  output logic             sync_err
);
  import mask_feature_extractor_pkg::*;

  localparam int PC_W = $clog2(WIDTH + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  state_t           state_q, state_n;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [ROW_W-1:0] min_row_q, min_row_n, max_row_q, max_row_n;
  logic [COL_W-1:0] min_col_q, min_col_n, max_col_q, max_col_n;
  logic             seen_q, seen_n;
  logic             err_n, load, clear;

  logic [CNT_W-1:0] f_count_q;
  logic [ROW_W-1:0] f_min_row_q, f_max_row_q;
  logic [COL_W-1:0] f_min_col_q, f_max_col_q;
  logic             f_empty_q, sync_err_q;

  logic [PC_W-1:0]  pc;
  logic [COL_W-1:0] first, last;
  logic             any;

  logic             accept, proc, restart;
  logic [ROW_W-1:0] idx;
  logic [CNT_W-1:0] b_count;
  logic [ROW_W-1:0] b_min_row, b_max_row;
  logic [COL_W-1:0] b_min_col, b_max_col;
  logic             b_seen;

  row_span_popcount #(
    .WIDTH (WIDTH),
    .PC_W  (PC_W),
    .IDX_W (COL_W)
  ) u_span (
    .row      (row_data),
    .popcount (pc),
    .first    (first),
    .last     (last),
    .any      (any)
  );

  assign row_ready = (state_q != ST_HOLD);
  assign accept    = row_valid && row_ready;

  always_comb begin
    state_n   = state_q;
    row_cnt_n = row_cnt_q;
    count_n   = count_q;
    min_row_n = min_row_q;
    max_row_n = max_row_q;
    min_col_n = min_col_q;
    max_col_n = max_col_q;
    seen_n    = seen_q;
    err_n     = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    proc      = 1'b0;
    restart   = 1'b0;
    idx       = row_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (row_sof) begin
            proc    = 1'b1;
            restart = 1'b1;
            idx     = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          proc = 1'b1;
          if (row_sof && (row_cnt_q != '0)) begin
            err_n   = 1'b1;
            restart = 1'b1;
            idx     = '0;
          end
        end
      end
      ST_HOLD: begin
        if (feat_ready) begin
          state_n = ST_IDLE;
          clear   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A restart folds the new row into freshly cleared accumulators in the same cycle.
    b_count   = restart ? '0       : count_q;
    b_min_row = restart ? ROW_LAST : min_row_q;
    b_max_row = restart ? '0       : max_row_q;
    b_min_col = restart ? COL_LAST : min_col_q;
    b_max_col = restart ? '0       : max_col_q;
    b_seen    = restart ? 1'b0     : seen_q;

    if (proc) begin
      count_n   = b_count + CNT_W'(pc);
      min_row_n = b_min_row;
      max_row_n = b_max_row;
      min_col_n = b_min_col;
      max_col_n = b_max_col;
      seen_n    = b_seen;
      if (any) begin
        if (idx < b_min_row) min_row_n = idx;
        max_row_n = idx;
        if (first < b_min_col) min_col_n = first;
        if (last > b_max_col)  max_col_n = last;
        seen_n = 1'b1;
      end
      if (idx == ROW_LAST) begin
        state_n   = ST_HOLD;
        row_cnt_n = '0;
        load      = 1'b1;
      end else begin
        state_n   = ST_ACCUM;
        row_cnt_n = idx + ROW_W'(1);
      end
    end

    if (clear) begin
      row_cnt_n = '0;
      count_n   = '0;
      min_row_n = ROW_LAST;
      max_row_n = '0;
      min_col_n = COL_LAST;
      max_col_n = '0;
      seen_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      count_q     <= '0;
      min_row_q   <= ROW_LAST;
      max_row_q   <= '0;
      min_col_q   <= COL_LAST;
      max_col_q   <= '0;
      seen_q      <= 1'b0;
      f_count_q   <= '0;
      f_min_row_q <= '0;
      f_max_row_q <= '0;
      f_min_col_q <= '0;
      f_max_col_q <= '0;
      f_empty_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      row_cnt_q  <= row_cnt_n;
      count_q    <= count_n;
      min_row_q  <= min_row_n;
      max_row_q  <= max_row_n;
      min_col_q  <= min_col_n;
      max_col_q  <= max_col_n;
      seen_q     <= seen_n;
      sync_err_q <= err_n;
      if (load) begin
        f_count_q   <= count_n;
        f_empty_q   <= !seen_n;
        f_min_row_q <= seen_n ? min_row_n : '0;
        f_max_row_q <= seen_n ? max_row_n : '0;
        f_min_col_q <= seen_n ? min_col_n : '0;
        f_max_col_q <= seen_n ? max_col_n : '0;
      end else if (clear) begin
        f_count_q   <= '0;
        f_empty_q   <= 1'b0;
        f_min_row_q <= '0;
        f_max_row_q <= '0;
        f_min_col_q <= '0;
        f_max_col_q <= '0;
      end
    end
  end

  assign feat_valid   = (state_q == ST_HOLD);
  assign feat_count   = f_count_q;
  assign feat_min_row = f_min_row_q;
  assign feat_max_row = f_max_row_q;
  assign feat_min_col = f_min_col_q;
  assign feat_max_col = f_max_col_q;
  assign feat_empty   = f_empty_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_mask_feature_extractor.sv
// tb/tb_mask_feature_extractor.sv - directed frames checked against a frame-level feature model
module tb_mask_feature_extractor;

  localparam int L = 8;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       row_valid, row_sof, feat_ready;
  logic [7:0] row_data;
  logic       row_ready, feat_valid, feat_empty, sync_err;
  logic [6:0] feat_count;
  logic [2:0] feat_min_row, feat_max_row, feat_min_col, feat_max_col;

  int nchecks = 0;
  int nerr    = 0;
  bit sync_exp = 1'b0;

  typedef struct {
    int count;
    int minr;
    int maxr;
    int minc;
    int maxc;
    int empty;
  } rec_t;

  rec_t q[$];

  mask_feature_extractor #(.LENGTH(L), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_sof      (row_sof),
    .row_data     (row_data),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .feat_count   (feat_count),
    .feat_min_row (feat_min_row),
    .feat_max_row (feat_max_row),
    .feat_min_col (feat_min_col),
    .feat_max_col (feat_max_col),
    .feat_empty   (feat_empty),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Features of a whole frame; row r occupies bits [8r+7:8r], column c is bit c of that byte.
  function automatic rec_t model(input logic [63:0] fr);
    rec_t r;
    r.count = 0; r.minr = L - 1; r.maxr = 0; r.minc = W - 1; r.maxc = 0; r.empty = 1;
    for (int rr = 0; rr < L; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        if (fr[rr * W + cc]) begin
          r.count++;
          r.empty = 0;
          if (rr < r.minr) r.minr = rr;
          if (rr > r.maxr) r.maxr = rr;
          if (cc < r.minc) r.minc = cc;
          if (cc > r.maxc) r.maxc = cc;
        end
      end
    end
    if (r.empty != 0) begin
      r.minr = 0; r.maxr = 0; r.minc = 0; r.maxc = 0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("row_ready_vs_hold", int'(row_ready), int'(!feat_valid));
      check("sync_err", int'(sync_err), int'(sync_exp));
      if (feat_valid) begin
        if (q.size() == 0) begin
          check("unexpected_record", 1, 0);
        end else begin
          check("rec_count", int'(feat_count), q[0].count);
          check("rec_min_row", int'(feat_min_row), q[0].minr);
          check("rec_max_row", int'(feat_max_row), q[0].maxr);
          check("rec_min_col", int'(feat_min_col), q[0].minc);
          check("rec_max_col", int'(feat_max_col), q[0].maxc);
          check("rec_empty", int'(feat_empty), q[0].empty);
          if (feat_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sync_exp = 1'b0;
  endtask

  task automatic send_row(input logic [7:0] d, input bit sof, input bit err);
    bit rdy;
    bit done;
    done = 1'b0;
    row_valid = 1'b1; row_sof = sof; row_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = row_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    if (!done) check("accept_timeout", 0, 1);
    sync_exp = err;
  endtask

  task automatic send_frame(input logic [63:0] fr, input bit first_err);
    q.push_back(model(fr));
    for (int r = 0; r < L; r++) begin
      send_row(fr[r * W +: 8], r == 0, (r == 0) && first_err);
      if (r < L - 1) check("valid_early", int'(feat_valid), 0);
    end
    row_valid = 1'b0; row_sof = 1'b0;
    check("valid_latency", int'(feat_valid), 1);
  endtask

  task automatic check_lit(input int c, input int r0, input int r1, input int c0, input int c1, input int e);
    check("lit_count", int'(feat_count), c);
    check("lit_min_row", int'(feat_min_row), r0);
    check("lit_max_row", int'(feat_max_row), r1);
    check("lit_min_col", int'(feat_min_col), c0);
    check("lit_max_col", int'(feat_max_col), c1);
    check("lit_empty", int'(feat_empty), e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row_ready"}, int'(row_ready), 1);
    check({tag, "_feat_valid"}, int'(feat_valid), 0);
    check({tag, "_sync_err"}, int'(sync_err), 0);
    check({tag, "_count"}, int'(feat_count), 0);
    check({tag, "_box"}, int'({feat_min_row, feat_max_row, feat_min_col, feat_max_col}), 0);
    check({tag, "_empty"}, int'(feat_empty), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f_zero, f_pix, f_bar, f_a, f_b, f_c, f_d;
    f_zero = 64'h0;
    f_pix  = 64'h0000_0000_2000_0000;
    f_bar  = 64'h0000_003C_3C3C_0000;
    f_a    = 64'h8100_0000_0000_0018;
    f_b    = 64'h0000_0000_0000_8100;
    f_c    = 64'h0102_0408_1020_4080;
    f_d    = 64'h0000_7E00_0000_0600;

    rst_n = 1'b0; row_valid = 1'b0; row_sof = 1'b0; row_data = '0; feat_ready = 1'b1;
    #23;
    check_reset_vals("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Hand-computed values pin the model.
    check("model_bar_count", model(f_bar).count, 12);
    check("model_a_box", model(f_a).minr * 1000 + model(f_a).maxr * 100 + model(f_a).minc * 10 + model(f_a).maxc, 707);

    send_frame(f_zero, 0);
    check_lit(0, 0, 0, 0, 0, 1);
    tick();
    check("consumed_valid", int'(feat_valid), 0);

    send_frame(f_pix, 0);
    check_lit(1, 3, 3, 5, 5, 0);
    tick();

    send_frame(f_bar, 0);
    check_lit(12, 2, 4, 2, 5, 0);
    tick();

    // Backpressure: record must stay put while the next frame's row 0 waits.
    feat_ready = 1'b0;
    send_frame(f_a, 0);
    row_valid = 1'b1; row_sof = 1'b1; row_data = f_d[7:0];
    for (int i = 0; i < 5; i++) begin
      check("bp_row_ready", int'(row_ready), 0);
      check("bp_valid", int'(feat_valid), 1);
      check("bp_count", int'(feat_count), 4);
      tick();
    end
    feat_ready = 1'b1;
    send_frame(f_d, 0);
    tick();

    // Unframed row in IDLE is dropped with an error pulse.
    send_row(8'hFF, 0, 1);
    row_valid = 1'b0;
    check("idle_drop_err", int'(sync_err), 1);
    tick();
    check("idle_drop_state", int'(row_ready), 1);

    // Mid-frame sof: the restart row becomes row 0 of the reported frame.
    send_row(8'hFF, 1, 0);
    send_row(8'hFF, 0, 0);
    send_row(8'hFF, 0, 0);
    send_frame(f_b, 1);
    check_lit(2, 1, 1, 0, 7, 0);
    tick();

    // Asynchronous reset while row 5 is on the bus.
    for (int r = 0; r < 5; r++) send_row(f_c[r * W +: 8], r == 0, 0);
    row_valid = 1'b1; row_sof = 1'b0; row_data = f_c[47:40];
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midframe_rst");
    row_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(f_c, 0);
    check_lit(8, 0, 7, 0, 7, 0);
    tick();

    // Asynchronous reset while a record is pending discards it.
    feat_ready = 1'b0;
    send_frame(f_bar, 0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_vals("hold_rst");
    tick();
    rst_n = 1'b1;
    feat_ready = 1'b1;
    tick();
    send_frame(f_pix, 0);
    check_lit(1, 3, 3, 5, 5, 0);
    tick();
    tick();

    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
